// File: rtl/reg_file_16x16.sv
// reg_file_16x16: general-purpose register file with two asynchronous read
// ports and one synchronous write port. R0 has no storage and reads zero.
//
// Ports:
//   clk       rising-edge clock for all register updates
//   rst_n     asynchronous active-low reset, clears every register
//   SrcReg1   read index, port 1     -> SrcData1
//   SrcReg2   read index, port 2     -> SrcData2
//   DstReg    write index
//   WriteReg  write enable
//   DstData   write data
//   SrcData1  read data, port 1 (combinational)
//   SrcData2  read data, port 2 (combinational)
//
// Build option:
//   RF_BYPASS_EN  when defined, a read of the register being written this
//                 cycle returns DstData instead of the stored value.

module reg_file_16x16 #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] SrcReg1,
  input  logic [ADDR_WIDTH-1:0] SrcReg2,
  input  logic [ADDR_WIDTH-1:0] DstReg,
  input  logic                  WriteReg,
  input  logic [DATA_WIDTH-1:0] DstData,
  output logic [DATA_WIDTH-1:0] SrcData1,
  output logic [DATA_WIDTH-1:0] SrcData2
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

  // Storage for R1..R(N-1); R0 is a constant zero on the read side.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

  // Cleared by reset, set by the first edge after release. Gating writes with
  // it makes an edge coincident with reset removal perform no write,
  // regardless of how the release and the edge are ordered.
  logic wr_arm_q;

  logic                  wr_fire_c;
  logic [DATA_WIDTH-1:0] rd1_c;
  logic [DATA_WIDTH-1:0] rd2_c;

  assign wr_fire_c = WriteReg && (DstReg != '0) && wr_arm_q;

  // Next-state: only the addressed register loads DstData, and only when the
  // write actually fires, so DstData is never sampled with WriteReg low.
  always_comb begin
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_fire_c && (DstReg == ADDR_WIDTH'(i))) begin
        regs_d[i] = DstData;
      end
    end
  end

  // Register array and write-arm flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_arm_q <= 1'b0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_arm_q <= 1'b1;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read muxes; index 0 matches no entry and falls through to zero.
  always_comb begin
    rd1_c = '0;
    rd2_c = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (SrcReg1 == ADDR_WIDTH'(i)) rd1_c = regs_q[i];
      if (SrcReg2 == ADDR_WIDTH'(i)) rd2_c = regs_q[i];
    end
  end

`ifdef RF_BYPASS_EN
  // Write-before-read forwarding; wr_fire_c already excludes R0 and reset.
  assign SrcData1 = (wr_fire_c && (DstReg == SrcReg1)) ? DstData : rd1_c;
  assign SrcData2 = (wr_fire_c && (DstReg == SrcReg2)) ? DstData : rd2_c;
`else
  // Stored contents only; the write-data mux stays off the read path.
  assign SrcData1 = rd1_c;
  assign SrcData2 = rd2_c;
`endif

endmodule

// File: tb/tb_reg_file_16x16.sv
// tb_reg_file_16x16: directed and randomized checks of reg_file_16x16
// against an array model of the sixteen registers.

module tb_reg_file_16x16;

  logic        clk;
  logic        clk_run;
  logic        rst_n;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;

  int n_tests;
  int n_fail;

  // Architectural model: register contents, and whether writes are accepted
  // yet (the edge that coincides with reset release writes nothing).
  logic [15:0] model [16];
  bit          armed;

  reg_file_16x16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .WriteReg (WriteReg),
    .DstData  (DstData),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2)
  );

  // Stoppable clock so reset can be exercised with no edges.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [3:0] s);
    if (s == 4'd0) return 16'h0000;
`ifdef RF_BYPASS_EN
    if (armed && WriteReg && DstReg != 4'd0 && DstReg == s) return DstData;
`endif
    return model[s];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    armed = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge: check reads before
  // and after the rising edge, updating the model at the edge.
  task automatic cycle(input logic we, input logic [3:0] dst, input logic [15:0] data,
                       input logic [3:0] s1, input logic [3:0] s2, input string tag);
    WriteReg = we; DstReg = dst; DstData = data; SrcReg1 = s1; SrcReg2 = s2;
    #1;
    chk({tag, "_pre1"}, SrcData1, exp_rd(s1));
    chk({tag, "_pre2"}, SrcData2, exp_rd(s2));
    @(posedge clk);
    if (armed && we && dst != 4'd0) model[dst] = data;
    #1;
    chk({tag, "_post1"}, SrcData1, exp_rd(s1));
    chk({tag, "_post2"}, SrcData2, exp_rd(s2));
    @(negedge clk);
  endtask

  // Release reset exactly at a rising edge carrying a write to R9, which must
  // be dropped; then idle so the design is armed before normal traffic.
  task automatic release_rst();
    WriteReg = 1'b1; DstReg = 4'd9; DstData = 16'h9999; SrcReg1 = 4'd9; SrcReg2 = 4'd5;
    clk_run = 1'b1;
    @(posedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_edge_r9", SrcData1, 16'h0000);
    chk("rel_edge_r5", SrcData2, 16'h0000);
    @(negedge clk);
    WriteReg = 1'b0;
    @(posedge clk);
    @(negedge clk);
    armed = 1'b1;
    chk("rel_after_r9", SrcData1, 16'h0000);
    chk("rel_after_r5", SrcData2, 16'h0000);
  endtask

  task automatic read_all(input string tag);
    WriteReg = 1'b0;
    for (int i = 0; i < 16; i++) begin
      SrcReg1 = 4'(i);
      SrcReg2 = 4'(16 - i);
      #1;
      chk({tag, "_a"}, SrcData1, exp_rd(SrcReg1));
      chk({tag, "_b"}, SrcData2, exp_rd(SrcReg2));
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    clk_run = 1'b1;
    rst_n = 1'b0;
    WriteReg = 1'b0; DstReg = 4'd0; DstData = 16'h0000; SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    clear_model();

    // Power-on reset: writes held off while in reset.
    WriteReg = 1'b1; DstReg = 4'd3; DstData = 16'hDEAD; SrcReg1 = 4'd3; SrcReg2 = 4'd15;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("por_r3", SrcData1, 16'h0000);
    chk("por_r15", SrcData2, 16'h0000);
    release_rst();

    // Basic writes, disabled write, R0 write.
    cycle(1'b1, 4'd3, 16'h1234, 4'd3, 4'd7, "wr_r3");
    cycle(1'b1, 4'd7, 16'hFFFF, 4'd3, 4'd7, "wr_r7");
    cycle(1'b0, 4'd3, 16'hAAAA, 4'd3, 4'd7, "nowr_r3");
    chk("r3_kept", SrcData1, 16'h1234);
    cycle(1'b1, 4'd0, 16'h5555, 4'd0, 4'd0, "wr_r0");
    chk("r0_zero", SrcData1, 16'h0000);

    // Same-cycle write and read of one register on both ports.
    cycle(1'b1, 4'd4, 16'h0001, 4'd1, 4'd2, "r4_init");
    cycle(1'b1, 4'd4, 16'h00F0, 4'd4, 4'd4, "r4_bypass");
    chk("r4_after", SrcData1, 16'h00F0);

    // Full sweep with mirrored index pairs.
    for (int i = 1; i < 16; i++) begin
      cycle(1'b1, 4'(i), 16'(i * 16'h1111), 4'(i), 4'(16 - i), "sweep_wr");
    end
    read_all("sweep_rd");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand");
    end

    // Reset with the clock stopped after writing R5.
    cycle(1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd0, "wr_r5");
    clk_run = 1'b0;
    WriteReg = 1'b0; SrcReg1 = 4'd5;
    #1;
    chk("r5_before_rst", SrcData1, 16'hBEEF);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("r5_in_rst", SrcData1, 16'h0000);
    #20;
    chk("r5_still_rst", SrcData1, 16'h0000);
    release_rst();
    read_all("after_rst1");

    // Reset asserted between edges while a write to R9 is pending.
    cycle(1'b1, 4'd9, 16'h1357, 4'd9, 4'd9, "wr_r9");
    WriteReg = 1'b1; DstReg = 4'd9; DstData = 16'h9999; SrcReg1 = 4'd9; SrcReg2 = 4'd3;
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("r9_mid_rst", SrcData1, 16'h0000);
    chk("r3_mid_rst", SrcData2, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    release_rst();
    read_all("after_rst2");
    cycle(1'b1, 4'd9, 16'hC0DE, 4'd9, 4'd0, "wr_r9_again");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
